// File: rtl/pcie_turnoff_init_pkg.sv
// Shared message codes and turn-off FSM state encoding for the PME_Turn_Off initiator.
package pcie_turnoff_init_pkg;

    localparam logic [7:0] C_MSG_PME_TURN_OFF = 8'h19;
    localparam logic [7:0] C_MSG_PME_TO_ACK   = 8'h1B;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRAIN    = 3'd1,
        S_SEND     = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4,
        S_TMO      = 3'd5
    } turnoff_state_t;

endpackage

// File: rtl/pcie_turnoff_tmr.sv
// Clear/enable ack timeout counter; expire is high in the enabled cycle where the count reaches G_TMO_VAL-1.
module pcie_turnoff_tmr #(
    parameter int G_TMO_W   = 24,
    parameter int G_TMO_VAL = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [G_TMO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == G_TMO_W'(G_TMO_VAL - 1));

endmodule

// File: rtl/pcie_turnoff_init.sv
// PME_Turn_Off initiator: drain non-posted TLPs, send PME_Turn_Off, collect PME_TO_Ack per link.
// Optional build macro PCIE_TURNOFF_RETRY_EN resends PME_Turn_Off up to G_RETRY times on timeout.
module pcie_turnoff_init
    import pcie_turnoff_init_pkg::*;
#(
    parameter int G_PORTS    = 1,
    parameter int G_NP_CNT_W = 6,
    parameter int G_TMO_W    = 24,
    parameter int G_TMO_VAL  = 10_000_000,
    parameter int G_RETRY    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pwr_off_req_i,
    input  logic [G_PORTS-1:0] port_en_i,
    input  logic               np_issue_i,
    input  logic               np_compl_i,
    output logic               block_np_o,
    output logic               msg_req_o,
    output logic [7:0]         msg_code_o,
    input  logic               msg_ack_i,
    input  logic [G_PORTS-1:0] pme_to_ack_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               tmo_o
);

`ifdef PCIE_TURNOFF_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif
    localparam int RETRY_MAX = RETRY_EN ? G_RETRY : 0;
    localparam int RETRY_W   = $clog2(G_RETRY + 2);

    turnoff_state_t          state, nxt;
    logic [G_NP_CNT_W-1:0]   np_cnt;
    logic [G_PORTS-1:0]      en_q;
    logic [G_PORTS-1:0]      ack_vec;
    logic [G_PORTS-1:0]      ack_new;
    logic [RETRY_W-1:0]      retry_cnt;
    logic                    all_acked;
    logic                    tmr_expire;

    function automatic logic [G_NP_CNT_W-1:0] np_next(input logic [G_NP_CNT_W-1:0] c,
                                                     input logic inc, input logic dec);
        if (inc && !dec && (c != '1))
            return c + 1'b1;
        if (dec && !inc && (c != '0))
            return c - 1'b1;
        return c;
    endfunction

    pcie_turnoff_tmr #(
        .G_TMO_W   (G_TMO_W),
        .G_TMO_VAL (G_TMO_VAL)
    ) u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state != S_WAIT_ACK),
        .en     (state == S_WAIT_ACK),
        .expire (tmr_expire)
    );

    assign ack_new   = ack_vec | (pme_to_ack_i & en_q);
    assign all_acked = (ack_new == en_q);

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:
                if (pwr_off_req_i) nxt = S_DRAIN;
            S_DRAIN:
                if (!pwr_off_req_i)   nxt = S_IDLE;
                else if (np_cnt == '0) nxt = S_SEND;
            S_SEND:
                if (msg_ack_i) nxt = (en_q == '0) ? S_DONE : S_WAIT_ACK;
            S_WAIT_ACK:
                // A completing ack beats both cancel and timer expiry.
                if (all_acked)          nxt = S_DONE;
                else if (!pwr_off_req_i) nxt = S_IDLE;
                else if (tmr_expire)
                    nxt = (int'(retry_cnt) < RETRY_MAX) ? S_SEND : S_TMO;
            S_DONE, S_TMO:
                if (!pwr_off_req_i) nxt = S_IDLE;
            default:
                nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            np_cnt     <= '0;
            en_q       <= '0;
            ack_vec    <= '0;
            retry_cnt  <= '0;
            block_np_o <= 1'b0;
            msg_req_o  <= 1'b0;
            msg_code_o <= 8'h00;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            tmo_o      <= 1'b0;
        end else begin
            state  <= nxt;
            np_cnt <= np_next(np_cnt, np_issue_i, np_compl_i);

            if (state == S_IDLE) begin
                retry_cnt <= '0;
                if (pwr_off_req_i) begin
                    en_q    <= port_en_i;
                    ack_vec <= '0;
                end
            end
            if (state == S_WAIT_ACK) begin
                ack_vec <= ack_new;
                if (nxt == S_SEND)
                    retry_cnt <= retry_cnt + 1'b1;
            end

            // Outputs are decoded from the next state so they are registered yet
            // line up with the state they describe; blocking covers the whole sequence.
            busy_o     <= (nxt != S_IDLE);
            block_np_o <= (nxt != S_IDLE);
            msg_req_o  <= (nxt == S_SEND);
            msg_code_o <= (nxt == S_SEND) ? C_MSG_PME_TURN_OFF : 8'h00;
            done_o     <= (nxt == S_DONE);
            tmo_o      <= (nxt == S_TMO);
        end
    end

endmodule

// File: tb/tb_pcie_turnoff_init.sv
// Directed testbench for pcie_turnoff_init (G_PORTS=2, G_TMO_VAL=16).
module tb_pcie_turnoff_init;

`ifdef PCIE_TURNOFF_RETRY_EN
    localparam int RETRY_EXP = 2;
`else
    localparam int RETRY_EXP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwr_off_req_i = 1'b0;
    logic [1:0] port_en_i = 2'b00;
    logic       np_issue_i = 1'b0;
    logic       np_compl_i = 1'b0;
    logic       block_np_o;
    logic       msg_req_o;
    logic [7:0] msg_code_o;
    logic       msg_ack_i = 1'b0;
    logic [1:0] pme_to_ack_i = 2'b00;
    logic       busy_o;
    logic       done_o;
    logic       tmo_o;

    int n_chk  = 0;
    int n_pass = 0;
    int req_pulses = 0;
    int pulses_at_start;
    logic req_prev = 1'b0;

    pcie_turnoff_init #(
        .G_PORTS    (2),
        .G_NP_CNT_W (6),
        .G_TMO_W    (8),
        .G_TMO_VAL  (16),
        .G_RETRY    (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pwr_off_req_i (pwr_off_req_i),
        .port_en_i     (port_en_i),
        .np_issue_i    (np_issue_i),
        .np_compl_i    (np_compl_i),
        .block_np_o    (block_np_o),
        .msg_req_o     (msg_req_o),
        .msg_code_o    (msg_code_o),
        .msg_ack_i     (msg_ack_i),
        .pme_to_ack_i  (pme_to_ack_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .tmo_o         (tmo_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        req_prev <= msg_req_o;
        if (msg_req_o && !req_prev)
            req_pulses <= req_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output vector order: {busy, block_np, msg_req, done, tmo}
    task automatic chk_out(input string tag, input logic [4:0] exp);
        chk(tag, {27'd0, busy_o, block_np_o, msg_req_o, done_o, tmo_o}, {27'd0, exp});
    endtask

    task automatic pulse_ack(input logic [1:0] a);
        pme_to_ack_i = a;
        tick(1);
        pme_to_ack_i = 2'b00;
    endtask

    task automatic msg_accept;
        msg_ack_i = 1'b1;
        tick(1);
        msg_ack_i = 1'b0;
    endtask

    initial begin
        // Reset
        tick(2);
        chk_out("reset_outs", 5'b00000);
        chk("reset_code", {24'd0, msg_code_o}, 32'h00);
        rst_n = 1'b1;
        tick(1);

        // 1: basic two-port sequence
        port_en_i = 2'b11;
        pwr_off_req_i = 1'b1;
        pulses_at_start = req_pulses;
        tick(1);
        chk_out("t1_drain", 5'b11000);
        tick(1);
        chk_out("t1_send", 5'b11100);
        chk("t1_code", {24'd0, msg_code_o}, 32'h19);
        tick(2);
        chk_out("t1_send_held", 5'b11100);
        msg_accept();
        chk_out("t1_wait", 5'b11000);
        pulse_ack(2'b01);
        chk_out("t1_ack0", 5'b11000);
        pulse_ack(2'b10);
        chk_out("t1_done", 5'b11010);
        chk("t1_pulses", req_pulses - pulses_at_start, 1);
        pwr_off_req_i = 1'b0;
        tick(1);
        chk_out("t1_release", 5'b00000);

        // 2: drain of outstanding non-posted requests
        np_issue_i = 1'b1;
        tick(3);
        np_issue_i = 1'b0;
        pwr_off_req_i = 1'b1;
        tick(2);
        chk_out("t2_drain3", 5'b11000);
        np_compl_i = 1'b1;
        tick(1);
        np_issue_i = 1'b1;
        tick(1);
        np_issue_i = 1'b0;
        chk_out("t2_drain2", 5'b11000);
        tick(1);
        chk_out("t2_drain1", 5'b11000);
        tick(1);
        np_compl_i = 1'b0;
        chk_out("t2_drain0", 5'b11000);
        tick(1);
        chk_out("t2_send", 5'b11100);
        msg_accept();
        // cancel in WAIT_ACK
        pwr_off_req_i = 1'b0;
        tick(1);
        chk_out("t2_cancel_wait", 5'b00000);

        // 3: timeout (with retries when enabled)
        pwr_off_req_i = 1'b1;
        pulses_at_start = req_pulses;
        tick(2);
        for (int r = 0; r <= RETRY_EXP; r++) begin
            msg_accept();
            chk_out("t3_wait", 5'b11000);
            tick(15);
            chk_out("t3_pre_expire", 5'b11000);
            tick(1);
            if (r < RETRY_EXP)
                chk_out("t3_retry_send", 5'b11100);
            else
                chk_out("t3_tmo", 5'b11001);
        end
        chk("t3_pulses", req_pulses - pulses_at_start, RETRY_EXP + 1);
        pwr_off_req_i = 1'b0;
        tick(1);
        chk_out("t3_release", 5'b00000);

        // 4: final ack on the expiry cycle
        pwr_off_req_i = 1'b1;
        tick(2);
        msg_accept();
        pulse_ack(2'b01);
        tick(14);
        chk_out("t4_pre", 5'b11000);
        pulse_ack(2'b10);
        chk_out("t4_done_wins", 5'b11010);
        pwr_off_req_i = 1'b0;
        tick(1);

        // 5: cancel in DRAIN, cancel during SEND, stray/unenabled acks
        np_issue_i = 1'b1;
        tick(1);
        np_issue_i = 1'b0;
        pwr_off_req_i = 1'b1;
        tick(1);
        chk_out("t5_drain", 5'b11000);
        pwr_off_req_i = 1'b0;
        tick(1);
        chk_out("t5_cancel_drain", 5'b00000);
        np_compl_i = 1'b1;
        tick(1);
        np_compl_i = 1'b0;
        pwr_off_req_i = 1'b1;
        tick(2);
        pwr_off_req_i = 1'b0;
        tick(2);
        chk_out("t5_send_ignores_cancel", 5'b11100);
        msg_accept();
        chk_out("t5_handshake_done", 5'b11000);
        tick(1);
        chk_out("t5_cancel_after_send", 5'b00000);
        pulse_ack(2'b11);
        chk_out("t5_stray_idle", 5'b00000);
        port_en_i = 2'b01;
        pwr_off_req_i = 1'b1;
        tick(1);
        port_en_i = 2'b11;
        tick(1);
        msg_accept();
        pulse_ack(2'b10);
        chk_out("t5_unenabled_ack", 5'b11000);
        pulse_ack(2'b01);
        chk_out("t5_done_en01", 5'b11010);
        pwr_off_req_i = 1'b0;
        tick(1);

        // 6: no enabled links, underflow guard, reset mid-sequence
        np_compl_i = 1'b1;
        tick(1);
        np_compl_i = 1'b0;
        port_en_i = 2'b00;
        pwr_off_req_i = 1'b1;
        tick(2);
        chk_out("t6_send_no_underflow", 5'b11100);
        msg_accept();
        chk_out("t6_done_en0", 5'b11010);
        pwr_off_req_i = 1'b0;
        tick(1);
        port_en_i = 2'b11;
        pwr_off_req_i = 1'b1;
        tick(2);
        msg_accept();
        chk_out("t6_wait", 5'b11000);
        rst_n = 1'b0;
        tick(1);
        chk_out("t6_reset_outs", 5'b00000);
        chk("t6_reset_code", {24'd0, msg_code_o}, 32'h00);
        pwr_off_req_i = 1'b0;
        rst_n = 1'b1;
        tick(2);
        chk_out("t6_idle_after_reset", 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
